// File: rtl/axi4_lite_master_if.sv
// Bundles the command port, the response port and the AXI4-Lite master
// channels of axi4_lite_master into one interface with master/slave views.
interface axi4_lite_master_if #(
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter int C_M_AXI_ADDR_WIDTH = 4
);
   // command port
   logic                              cmd_valid;
   logic                              cmd_ready;
   logic                              cmd_write;
   logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr;
   logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata;
   logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb;
   // response port
   logic                              rsp_valid;
   logic                              rsp_ready;
   logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata;
   logic [1:0]                        rsp_resp;
   logic                              rsp_err;
   // AXI4-Lite write address / data / response
   logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr;
   logic [2:0]                        m_axi_awprot;
   logic                              m_axi_awvalid;
   logic                              m_axi_awready;
   logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_wdata;
   logic [C_M_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb;
   logic                              m_axi_wvalid;
   logic                              m_axi_wready;
   logic [1:0]                        m_axi_bresp;
   logic                              m_axi_bvalid;
   logic                              m_axi_bready;
   // AXI4-Lite read address / data
   logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_araddr;
   logic [2:0]                        m_axi_arprot;
   logic                              m_axi_arvalid;
   logic                              m_axi_arready;
   logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_rdata;
   logic [1:0]                        m_axi_rresp;
   logic                              m_axi_rvalid;
   logic                              m_axi_rready;

   // View used by the initiator itself
   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
      output cmd_ready,
      output rsp_valid, rsp_rdata, rsp_resp, rsp_err,
      input  rsp_ready,
      output m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
      input  m_axi_awready,
      output m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
      input  m_axi_wready,
      input  m_axi_bresp, m_axi_bvalid,
      output m_axi_bready,
      output m_axi_araddr, m_axi_arprot, m_axi_arvalid,
      input  m_axi_arready,
      input  m_axi_rdata, m_axi_rresp, m_axi_rvalid,
      output m_axi_rready
   );

   // View used by whoever issues commands and plays the AXI slave
   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
      input  cmd_ready,
      input  rsp_valid, rsp_rdata, rsp_resp, rsp_err,
      output rsp_ready,
      input  m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
      output m_axi_awready,
      input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
      output m_axi_wready,
      output m_axi_bresp, m_axi_bvalid,
      input  m_axi_bready,
      input  m_axi_araddr, m_axi_arprot, m_axi_arvalid,
      output m_axi_arready,
      output m_axi_rdata, m_axi_rresp, m_axi_rvalid,
      input  m_axi_rready
   );
endinterface

// File: rtl/axi4_lite_master.sv
// AXI4-Lite initiator: converts one valid/ready command at a time into a
// single-beat AXI4-Lite write or read and returns the slave's response.
// Every output comes straight from a register.
module axi4_lite_master #(
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter int C_M_AXI_ADDR_WIDTH = 4
) (
   input logic                  m_axi_aclk,
   input logic                  m_axi_aresetn,
   axi4_lite_master_if.master   bus
);
   localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;

   typedef enum logic [2:0] {
      IDLE,
      WR_REQ,
      WR_RESP,
      RD_REQ,
      RD_RESP,
      RSP
   } state_t;

   state_t                          r_state;
   logic                            r_cmd_ready;
   logic                            r_rsp_valid;
   logic [C_M_AXI_DATA_WIDTH-1:0]   r_rsp_rdata;
   logic [1:0]                      r_rsp_resp;
   logic                            r_rsp_err;
   logic [C_M_AXI_ADDR_WIDTH-1:0]   r_awaddr;
   logic                            r_awvalid;
   logic [C_M_AXI_DATA_WIDTH-1:0]   r_wdata;
   logic [STRB_W-1:0]               r_wstrb;
   logic                            r_wvalid;
   logic                            r_bready;
   logic [C_M_AXI_ADDR_WIDTH-1:0]   r_araddr;
   logic                            r_arvalid;
   logic                            r_rready;
   logic                            r_aw_done;
   logic                            r_w_done;

   // Handshakes seen this cycle on the two write request channels, and the
   // "done" flags as they will be after this edge.
   logic w_aw_hs;
   logic w_w_hs;
   logic w_aw_done_nxt;
   logic w_w_done_nxt;

   assign w_aw_hs       = r_awvalid & bus.m_axi_awready;
   assign w_w_hs        = r_wvalid & bus.m_axi_wready;
   assign w_aw_done_nxt = r_aw_done | w_aw_hs;
   assign w_w_done_nxt  = r_w_done | w_w_hs;

   // Transaction sequencer: state plus every registered output in one place
   always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
      // NOTE: async reset clears every output register, so an in-flight
      // transaction or a pending response simply vanishes.
      if (!m_axi_aresetn) begin
         r_state     <= IDLE;
         r_cmd_ready <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_resp  <= 2'b00;
         r_rsp_err   <= 1'b0;
         r_awaddr    <= '0;
         r_awvalid   <= 1'b0;
         r_wdata     <= '0;
         r_wstrb     <= '0;
         r_wvalid    <= 1'b0;
         r_bready    <= 1'b0;
         r_araddr    <= '0;
         r_arvalid   <= 1'b0;
         r_rready    <= 1'b0;
         r_aw_done   <= 1'b0;
         r_w_done    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every branch below
         // reads the pre-edge register values regardless of statement order.
         unique case (r_state)
            IDLE: begin
               if (bus.cmd_valid && r_cmd_ready) begin
                  r_cmd_ready <= 1'b0;
                  if (bus.cmd_write) begin
                     r_awaddr  <= bus.cmd_addr;
                     r_wdata   <= bus.cmd_wdata;
                     r_wstrb   <= bus.cmd_wstrb;
                     r_awvalid <= 1'b1;
                     r_wvalid  <= 1'b1;
                     r_aw_done <= 1'b0;
                     r_w_done  <= 1'b0;
                     r_state   <= WR_REQ;
                  end else begin
                     r_araddr  <= bus.cmd_addr;
                     r_arvalid <= 1'b1;
                     r_state   <= RD_REQ;
                  end
               end else begin
                  // Ready rises on the first edge after reset release
                  r_cmd_ready <= 1'b1;
               end
            end

            WR_REQ: begin
               if (w_aw_hs) begin
                  r_awvalid <= 1'b0;
                  r_aw_done <= 1'b1;
               end
               if (w_w_hs) begin
                  r_wvalid <= 1'b0;
                  r_w_done <= 1'b1;
               end
               // AW and W may finish on the same edge or on different ones
               if (w_aw_done_nxt && w_w_done_nxt) begin
                  r_bready <= 1'b1;
                  r_state  <= WR_RESP;
               end
            end

            WR_RESP: begin
               if (bus.m_axi_bvalid && r_bready) begin
                  r_rsp_resp  <= bus.m_axi_bresp;
                  r_rsp_err   <= bus.m_axi_bresp[1];
                  r_rsp_rdata <= '0;
                  r_bready    <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_state     <= RSP;
               end
            end

            RD_REQ: begin
               if (r_arvalid && bus.m_axi_arready) begin
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
                  r_state   <= RD_RESP;
               end
            end

            RD_RESP: begin
               if (bus.m_axi_rvalid && r_rready) begin
                  r_rsp_rdata <= bus.m_axi_rdata;
                  r_rsp_resp  <= bus.m_axi_rresp;
                  r_rsp_err   <= bus.m_axi_rresp[1];
                  r_rready    <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_state     <= RSP;
               end
            end

            RSP: begin
               if (bus.rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_cmd_ready <= 1'b1;
                  r_state     <= IDLE;
               end
            end

            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.cmd_ready     = r_cmd_ready;
   assign bus.rsp_valid     = r_rsp_valid;
   assign bus.rsp_rdata     = r_rsp_rdata;
   assign bus.rsp_resp      = r_rsp_resp;
   assign bus.rsp_err       = r_rsp_err;
   assign bus.m_axi_awaddr  = r_awaddr;
   assign bus.m_axi_awprot  = 3'b000;
   assign bus.m_axi_awvalid = r_awvalid;
   assign bus.m_axi_wdata   = r_wdata;
   assign bus.m_axi_wstrb   = r_wstrb;
   assign bus.m_axi_wvalid  = r_wvalid;
   assign bus.m_axi_bready  = r_bready;
   assign bus.m_axi_araddr  = r_araddr;
   assign bus.m_axi_arprot  = 3'b000;
   assign bus.m_axi_arvalid = r_arvalid;
   assign bus.m_axi_rready  = r_rready;

endmodule

// File: tb/tb_axi4_lite_master.sv
// Self-checking bench for axi4_lite_master: a delay-programmable AXI slave
// with a small word memory, a protocol monitor, a table of directed vectors,
// hand sequences for reset and back-to-back issue, and a randomized phase
// checked against a byte-strobe memory model and a latency formula.
`timescale 1ns/1ps
module tb_axi4_lite_master;
   logic clk;
   logic rst_n;

   axi4_lite_master_if #(.C_M_AXI_DATA_WIDTH(32), .C_M_AXI_ADDR_WIDTH(4)) bus ();

   axi4_lite_master #(.C_M_AXI_DATA_WIDTH(32), .C_M_AXI_ADDR_WIDTH(4)) dut (
      .m_axi_aclk    (clk),
      .m_axi_aresetn (rst_n),
      .bus           (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int viol  = 0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- slave model ----------------
   int          cfg_aw, cfg_w, cfg_b, cfg_ar, cfg_r;
   logic [1:0]  cfg_resp;
   logic [31:0] sl_mem [4];
   logic [3:0]  sl_awaddr, sl_araddr;
   logic [31:0] sl_wdata;
   logic [3:0]  sl_wstrb;
   logic        s_aw_hs, s_w_hs, s_b_hs, s_ar_hs, s_r_hs;
   int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
   bit          aw_got, w_got, b_wait, r_wait;

   // Sample handshakes mid-cycle; those signals are stable until the next edge
   always @(negedge clk) begin
      s_aw_hs = bus.m_axi_awvalid & bus.m_axi_awready;
      s_w_hs  = bus.m_axi_wvalid  & bus.m_axi_wready;
      s_b_hs  = bus.m_axi_bvalid  & bus.m_axi_bready;
      s_ar_hs = bus.m_axi_arvalid & bus.m_axi_arready;
      s_r_hs  = bus.m_axi_rvalid  & bus.m_axi_rready;
      if (s_aw_hs) sl_awaddr = bus.m_axi_awaddr;
      if (s_w_hs) begin
         sl_wdata = bus.m_axi_wdata;
         sl_wstrb = bus.m_axi_wstrb;
      end
      if (s_ar_hs) sl_araddr = bus.m_axi_araddr;
   end

   // Slave reaction, applied just after each edge
   always @(posedge clk) begin
      #1;
      if (!rst_n) begin
         bus.m_axi_awready = 1'b0; bus.m_axi_wready = 1'b0; bus.m_axi_bvalid = 1'b0;
         bus.m_axi_arready = 1'b0; bus.m_axi_rvalid = 1'b0;
         aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
         aw_got = 0; w_got = 0; b_wait = 0; r_wait = 0;
      end else begin
         if (s_aw_hs) begin
            bus.m_axi_awready = 1'b0; aw_cnt = 0; aw_got = 1;
         end else if (bus.m_axi_awvalid) begin
            if (aw_cnt == cfg_aw) bus.m_axi_awready = 1'b1; else aw_cnt++;
         end
         if (s_w_hs) begin
            bus.m_axi_wready = 1'b0; w_cnt = 0; w_got = 1;
         end else if (bus.m_axi_wvalid) begin
            if (w_cnt == cfg_w) bus.m_axi_wready = 1'b1; else w_cnt++;
         end
         if (s_b_hs) bus.m_axi_bvalid = 1'b0;
         if (aw_got && w_got) begin
            aw_got = 0; w_got = 0; b_wait = 1; b_cnt = 0;
            for (int b = 0; b < 4; b++)
               if (sl_wstrb[b]) sl_mem[sl_awaddr[3:2]][8*b +: 8] = sl_wdata[8*b +: 8];
         end
         if (b_wait) begin
            if (b_cnt == cfg_b) begin
               bus.m_axi_bvalid = 1'b1; bus.m_axi_bresp = cfg_resp; b_wait = 0;
            end else b_cnt++;
         end
         if (s_ar_hs) begin
            bus.m_axi_arready = 1'b0; ar_cnt = 0; r_wait = 1; r_cnt = 0;
         end else if (bus.m_axi_arvalid) begin
            if (ar_cnt == cfg_ar) bus.m_axi_arready = 1'b1; else ar_cnt++;
         end
         if (s_r_hs) bus.m_axi_rvalid = 1'b0;
         if (r_wait) begin
            if (r_cnt == cfg_r) begin
               bus.m_axi_rvalid = 1'b1;
               bus.m_axi_rdata  = sl_mem[sl_araddr[3:2]];
               bus.m_axi_rresp  = cfg_resp;
               r_wait = 0;
            end else r_cnt++;
         end
      end
   end

   // ---------------- protocol monitor ----------------
   logic       p_awv, p_awhs, p_wv, p_whs, p_arv, p_arhs;
   logic [3:0] p_awaddr, p_araddr, p_wstrb;
   logic [31:0] p_wdata;
   initial begin
      p_awv = 0; p_awhs = 0; p_wv = 0; p_whs = 0; p_arv = 0; p_arhs = 0;
   end
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.m_axi_awvalid && bus.m_axi_arvalid) viol++;
         if (bus.m_axi_bready && (bus.m_axi_awvalid || bus.m_axi_wvalid)) viol++;
         if (bus.m_axi_rready && bus.m_axi_arvalid) viol++;
         if (bus.m_axi_awprot !== 3'b000 || bus.m_axi_arprot !== 3'b000) viol++;
         if (p_awv && !p_awhs && (!bus.m_axi_awvalid || bus.m_axi_awaddr !== p_awaddr)) viol++;
         if (p_wv && !p_whs && (!bus.m_axi_wvalid || bus.m_axi_wdata !== p_wdata ||
                                bus.m_axi_wstrb !== p_wstrb)) viol++;
         if (p_arv && !p_arhs && (!bus.m_axi_arvalid || bus.m_axi_araddr !== p_araddr)) viol++;
         if (p_awhs && bus.m_axi_awvalid) viol++;
         if (p_whs && bus.m_axi_wvalid) viol++;
         if (p_arhs && bus.m_axi_arvalid) viol++;
      end
      p_awv = bus.m_axi_awvalid; p_awhs = bus.m_axi_awvalid & bus.m_axi_awready;
      p_wv  = bus.m_axi_wvalid;  p_whs  = bus.m_axi_wvalid & bus.m_axi_wready;
      p_arv = bus.m_axi_arvalid; p_arhs = bus.m_axi_arvalid & bus.m_axi_arready;
      p_awaddr = bus.m_axi_awaddr; p_wdata = bus.m_axi_wdata;
      p_wstrb = bus.m_axi_wstrb; p_araddr = bus.m_axi_araddr;
   end

   // ---------------- reference memory ----------------
   logic [31:0] model_mem [4];

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   // One complete transaction with rsp_ready held low for 'hold' cycles
   task automatic run_txn(input string tag, input bit wr, input logic [3:0] addr,
                          input logic [31:0] data, input logic [3:0] strb,
                          input int awd, input int wd, input int bd, input int ard,
                          input int rd, input logic [1:0] resp, input int hold,
                          input logic [31:0] exp_rdata, input logic [1:0] exp_resp,
                          input int exp_lat);
      int wait_n;
      int lat;
      cfg_aw = awd; cfg_w = wd; cfg_b = bd; cfg_ar = ard; cfg_r = rd; cfg_resp = resp;
      bus.cmd_write = wr; bus.cmd_addr = addr; bus.cmd_wdata = data; bus.cmd_wstrb = strb;
      bus.cmd_valid = 1'b1;
      wait_n = 0;
      do begin
         @(negedge clk);
         wait_n++;
      end while (!bus.cmd_ready && wait_n < 20);
      if (!bus.cmd_ready) begin
         check({tag, "_accept_timeout"}, 32'd1, 32'd0);
         bus.cmd_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      lat = 0;
      while (!bus.rsp_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_rdata"}, bus.rsp_rdata, exp_rdata);
      check({tag, "_resp"}, {30'd0, bus.rsp_resp}, {30'd0, exp_resp});
      check({tag, "_err"}, {31'd0, bus.rsp_err}, {31'd0, exp_resp[1]});
      check({tag, "_cmd_ready_busy"}, {31'd0, bus.cmd_ready}, 32'd0);
      if (wr) begin
         check({tag, "_awaddr"}, {28'd0, sl_awaddr}, {28'd0, addr});
         check({tag, "_wdata"}, sl_wdata, data);
         check({tag, "_wstrb"}, {28'd0, sl_wstrb}, {28'd0, strb});
         model_mem[addr[3:2]] = merge(model_mem[addr[3:2]], data, strb);
      end else begin
         check({tag, "_araddr"}, {28'd0, sl_araddr}, {28'd0, addr});
      end
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         check({tag, "_hold_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
         check({tag, "_hold_rdata"}, bus.rsp_rdata, exp_rdata);
         check({tag, "_hold_resp"}, {30'd0, bus.rsp_resp}, {30'd0, exp_resp});
         check({tag, "_hold_cmd_ready"}, {31'd0, bus.cmd_ready}, 32'd0);
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      check({tag, "_rsp_drop"}, {31'd0, bus.rsp_valid}, 32'd0);
      check({tag, "_cmd_ready_back"}, {31'd0, bus.cmd_ready}, 32'd1);
   endtask

   typedef struct {
      string       tag;
      bit          wr;
      logic [3:0]  addr;
      logic [31:0] data;
      logic [3:0]  strb;
      int          awd, wd, bd, ard, rd;
      logic [1:0]  resp;
      int          hold;
      logic [31:0] exp_rdata;
      logic [1:0]  exp_resp;
      int          exp_lat;
   } vec_t;

   vec_t vecs [9];

   initial begin
      int t1, t2, n;
      // Directed vectors; latency = 2 + max(aw,w) + b for writes, 2 + ar + r for reads
      vecs[0] = '{"wr0_zero",  1, 4'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 0, 32'h0,        2'b00, 2};
      vecs[1] = '{"wr1_zero",  1, 4'h8, 32'h0000000A, 4'hF, 0, 0, 0, 0, 0, 2'b00, 0, 32'h0,        2'b00, 2};
      vecs[2] = '{"rd2_zero",  0, 4'h8, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b00, 0, 32'h0000000A, 2'b00, 2};
      vecs[3] = '{"wr3_awslow",1, 4'h4, 32'hCAFEF00D, 4'hF, 5, 2, 0, 0, 0, 2'b00, 0, 32'h0,        2'b00, 7};
      vecs[4] = '{"rd4_slverr",0, 4'h4, 32'h0,        4'h0, 0, 0, 0, 2, 4, 2'b10, 3, 32'hCAFEF00D, 2'b10, 8};
      vecs[5] = '{"wr5_strb",  1, 4'hC, 32'h11223344, 4'h5, 0, 0, 1, 0, 0, 2'b11, 1, 32'h0,        2'b11, 3};
      vecs[6] = '{"rd6_strb",  0, 4'hC, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b00, 0, 32'h00220044, 2'b00, 2};
      vecs[7] = '{"wr7_wslow", 1, 4'h0, 32'hA5A5A5A5, 4'h8, 0, 3, 0, 0, 0, 2'b01, 0, 32'h0,        2'b01, 5};
      vecs[8] = '{"rd8_arslow",0, 4'h0, 32'h0,        4'h0, 0, 0, 0, 1, 0, 2'b00, 1, 32'hA5000000, 2'b00, 3};

      for (int i = 0; i < 4; i++) begin
         sl_mem[i] = 32'h0;
         model_mem[i] = 32'h0;
      end
      cfg_aw = 0; cfg_w = 0; cfg_b = 0; cfg_ar = 0; cfg_r = 0; cfg_resp = 2'b00;
      bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
      bus.cmd_wstrb = '0; bus.rsp_ready = 0;
      bus.m_axi_awready = 0; bus.m_axi_wready = 0; bus.m_axi_bvalid = 0; bus.m_axi_bresp = 0;
      bus.m_axi_arready = 0; bus.m_axi_rvalid = 0; bus.m_axi_rdata = 0; bus.m_axi_rresp = 0;
      rst_n = 1'b0;

      // Reset state
      #12;
      check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
      check("rst_valids", {28'd0, bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_arvalid,
                           bus.rsp_valid}, 32'd0);
      check("rst_readies", {30'd0, bus.m_axi_bready, bus.m_axi_rready}, 32'd0);
      check("rst_rsp", {bus.rsp_rdata[29:0], bus.rsp_resp}, 32'd0);
      check("rst_addr", {20'd0, bus.m_axi_awaddr, bus.m_axi_araddr, bus.m_axi_wstrb}, 32'd0);
      check("rst_wdata", bus.m_axi_wdata, 32'd0);
      #11 rst_n = 1'b1;
      @(posedge clk); #1;
      check("rel_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);

      // Table-driven directed vectors
      for (int i = 0; i < 9; i++)
         run_txn(vecs[i].tag, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].strb,
                 vecs[i].awd, vecs[i].wd, vecs[i].bd, vecs[i].ard, vecs[i].rd,
                 vecs[i].resp, vecs[i].hold, vecs[i].exp_rdata, vecs[i].exp_resp,
                 vecs[i].exp_lat);

      // Reset in the middle of a stalled write request
      cfg_aw = 10; cfg_w = 10;
      bus.cmd_write = 1; bus.cmd_addr = 4'h4; bus.cmd_wdata = 32'h0BADF00D;
      bus.cmd_wstrb = 4'hF; bus.cmd_valid = 1;
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.cmd_ready && n < 20);
      @(posedge clk); #1;
      bus.cmd_valid = 0;
      @(posedge clk); #1;
      check("mid_wr_awvalid", {31'd0, bus.m_axi_awvalid}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_valids", {29'd0, bus.m_axi_awvalid, bus.m_axi_wvalid, bus.rsp_valid}, 32'd0);
      check("arst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
      @(posedge clk); #3 rst_n = 1'b1;
      @(posedge clk); #1;
      check("arst_rel_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
      run_txn("post_rst_rd", 0, 4'h4, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 0,
              model_mem[1], 2'b00, 2);

      // Back-to-back write then read, cmd_valid held, rsp_ready always high
      cfg_aw = 0; cfg_w = 0; cfg_b = 0; cfg_ar = 0; cfg_r = 0; cfg_resp = 2'b00;
      bus.rsp_ready = 1;
      bus.cmd_write = 1; bus.cmd_addr = 4'h8; bus.cmd_wdata = 32'h12345678;
      bus.cmd_wstrb = 4'hF; bus.cmd_valid = 1;
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.cmd_ready && n < 20);
      @(posedge clk); #1;
      t1 = cyc;
      bus.cmd_write = 0;
      model_mem[2] = 32'h12345678;
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.cmd_ready && n < 20);
      @(posedge clk); #1;
      t2 = cyc;
      bus.cmd_valid = 0;
      check("b2b_spacing", t2 - t1, 32'd4);
      n = 0;
      while (!bus.rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
      check("b2b_rd_valid", {31'd0, bus.rsp_valid}, 32'd1);
      check("b2b_rd_data", bus.rsp_rdata, model_mem[2]);
      @(posedge clk); #1;
      bus.rsp_ready = 0;

      // Randomized traffic against the memory model and latency formula
      for (int i = 0; i < 40; i++) begin
         bit          wr;
         logic [3:0]  a;
         logic [31:0] d;
         logic [3:0]  s;
         int          awd, wd, bd, ard, rd, hold, mx;
         logic [1:0]  rsp;
         wr  = 1'($urandom_range(0, 1));
         a   = {2'($urandom_range(0, 3)), 2'b00};
         d   = $urandom;
         s   = 4'($urandom_range(0, 15));
         awd = $urandom_range(0, 3); wd = $urandom_range(0, 3); bd = $urandom_range(0, 2);
         ard = $urandom_range(0, 3); rd = $urandom_range(0, 3);
         rsp = 2'($urandom_range(0, 3));
         hold = $urandom_range(0, 2);
         mx = (awd > wd) ? awd : wd;
         if (wr)
            run_txn("rnd_wr", 1, a, d, s, awd, wd, bd, ard, rd, rsp, hold,
                    32'h0, rsp, 2 + mx + bd);
         else
            run_txn("rnd_rd", 0, a, d, s, awd, wd, bd, ard, rd, rsp, hold,
                    model_mem[a[3:2]], rsp, 2 + ard + rd);
      end

      check("protocol_violations", viol, 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule

// File: doc/axi4_lite_master.md
# axi4_lite_master

AXI4-Lite initiator (master) that turns single-beat commands from a simple valid/ready command port into AXI4-Lite write or read transactions, and returns the slave's response on a response port. It sits on the master side of the peripheral bus and drives register-mapped slaves such as the button controller. The intended uses are a hardware sequencer and testbench-free register access. One transaction is outstanding at a time.

## Interface
- C_M_AXI_DATA_WIDTH, 32, data width (only 32 supported)
- C_M_AXI_ADDR_WIDTH, 4, address width
- m_axi_aclk  in  1  system clock, all logic on rising edge
- m_axi_aresetn  in  1  reset; asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  32  write data (ignored for reads)
- cmd_wstrb  in  4  byte strobes (ignored for reads)
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
- rsp_rdata  out  32  read data; 0 for writes
- rsp_resp  out  2  captured BRESP/RRESP
- rsp_err  out  1  rsp_resp[1] (SLVERR/DECERR)
- m_axi_awaddr/awprot/awvalid/awready, m_axi_wdata/wstrb/wvalid/wready, m_axi_bresp/bvalid/bready, m_axi_araddr/arprot/arvalid/arready, m_axi_rdata/rresp/rvalid/rready: standard AXI4-Lite master ports. awprot and arprot are tied to 3'b000.

## Operation
- The FSM has states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- All outputs are registered.
- Reset values:
  - state = IDLE.
  - All *valid and *ready outputs = 0, including cmd_ready.
  - rsp_* = 0, awaddr/araddr/wdata/wstrb = 0.
- IDLE:
  - cmd_ready is 1 from the first edge after reset release.
  - On acceptance, latch addr/wdata/wstrb into the AXI address/data registers and clear cmd_ready.
  - If cmd_write = 1: go to WR_REQ with awvalid = wvalid = 1. Otherwise go to RD_REQ with arvalid = 1.
- WR_REQ:
  - AW and W complete independently. awvalid clears on the awready edge; wvalid clears on the wready edge.
  - aw_done and w_done flags record each handshake.
  - When both are done (same or different edges), go to WR_RESP with bready = 1.
- WR_RESP:
  - On bvalid & bready: capture bresp, set rsp_rdata = 0, clear bready, set rsp_valid = 1, go to RSP.
- RD_REQ:
  - On arready: clear arvalid, set rready = 1, go to RD_RESP.
- RD_RESP:
  - On rvalid & rready: capture rdata and rresp, clear rready, set rsp_valid = 1, go to RSP.
- RSP:
  - rsp_* are held stable until rsp_ready.
  - On rsp_ready: clear rsp_valid, set cmd_ready = 1, go to IDLE.
- Protocol rules:
  - A valid is never dropped before its handshake.
  - Address, data and strobes are stable while their valid is high.
  - bready is 0 outside WR_RESP; rready is 0 outside RD_RESP. Early bvalid/rvalid is therefore not consumed.
- Async reset in any state returns immediately to reset values. Any in-flight transaction or pending response is discarded.

## Timing
- Acceptance is at edge E0.
- AW/W/AR valids are high from E0.
- With a zero-wait slave (ready high, response registered one cycle later):
  - Address/data handshake at E1.
  - B/R handshake at E2.
  - rsp_valid high after E2.
- With rsp_ready = 1 at E3: cmd_ready high after E3. Minimum spacing is 4 cycles per transaction.
- Each wait cycle on awready, wready, arready, bvalid or rvalid adds exactly one cycle.
- AW and W stalls overlap, so the write request phase costs max(AW wait, W wait).
- rsp_err updates on the same edge as rsp_resp.

## Test plan
- Zero-wait write addr 0x4, data 0xDEADBEEF, strb 0xF -> awaddr = 0x4 and wdata = 0xDEADBEEF handshake at E1; rsp_valid after E2; rsp_resp = 0, rsp_rdata = 0, rsp_err = 0.
- Zero-wait read addr 0x8, slave returns 0x0000000A with rresp = 0 -> rsp_rdata = 0x0000000A and rsp_valid after E2; cmd_ready back after rsp_ready.
- Write where wready arrives 3 cycles before awready (awready delayed 5) -> wvalid drops after its handshake, awvalid held 5 cycles with stable awaddr; bready rises only after both are done; no B consumed early.
- Read with arready delay 2, rvalid delay 4, rresp = 2'b10, rsp_ready held low 3 cycles -> rsp_resp = 2, rsp_err = 1; rsp_* stable all 3 cycles; cmd_ready stays 0 until the rsp_ready edge.
- Assert m_axi_aresetn low mid-WR_REQ with awvalid = 1 -> awvalid, wvalid and rsp_valid are 0 immediately; after release cmd_ready = 1 on the next edge; a following read completes normally.
- Back-to-back write then read with cmd_valid held and rsp_ready = 1 -> second command accepted exactly 4 cycles after the first; no overlap of AW/AR valids.
